rf_writeback_arbiter: RTL and testbench

- Initiator side of the register-file write port. It merges two result sources into the single RF write port (we/rd/din).
- Pipeline writeback source: in-order, high priority, holds its beat while stalled.
- Multi-cycle unit source (mul/div, long loads): valid/ready handshake, buffered in a small FIFO.
- Filters x0 writes, prevents starvation of the FIFO, and exports a pending-write scoreboard so decode can stall on RAW hazards against queued results.

---
 rtl/rf_writeback_arbiter_pkg.sv | 31 +++
 rtl/rf_writeback_arbiter_wb_fifo.sv | 83 ++++++++
 rtl/rf_writeback_arbiter.sv | 165 ++++++++++++++++
 tb/tb_rf_writeback_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_writeback_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rf_writeback_arbiter_pkg
// Shared types and constants for the register-file writeback arbiter.
//   REG_ADDR_W  : register index width
//   REG_ZERO    : index of the hard-wired zero register (never written)
//   wb_beat_t   : default {rd, data} beat layout (32-bit data)
//   wb_src_e    : which source wins the RF write slot in a given cycle
// -----------------------------------------------------------------------------
package rf_writeback_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [31:0]           data;
  } wb_beat_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_PIPE = 2'd1,
    WIN_FIFO = 2'd2,
    WIN_MC   = 2'd3
  } wb_src_e;

  // A beat only produces an RF write when it targets a real register.
  function automatic logic writes_reg(input logic [REG_ADDR_W-1:0] rd);
    return rd != REG_ZERO;
  endfunction

endpackage

// File: rtl/rf_writeback_arbiter_wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Synchronous DEPTH-entry FIFO holding multi-cycle results awaiting the RF
// write port. Also exposes every slot's {valid, rd} so the parent can build a
// pending-write scoreboard.
//   clk, reset     : clock, synchronous active-high reset (empties the FIFO)
//   push, push_beat: enqueue request and beat (ignored while full, even if a
//                    pop happens in the same cycle)
//   pop            : dequeue request (ignored while empty)
//   head           : beat at the read pointer
//   full, empty    : occupancy flags
//   count          : number of valid entries (0..DEPTH)
//   ent_valid      : per-slot valid bit
//   ent_rd         : per-slot destination register
// -----------------------------------------------------------------------------
module wb_fifo
  import rf_writeback_arbiter_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter type beat_t = wb_beat_t,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                push,
  input  beat_t                               push_beat,
  input  logic                                pop,
  output beat_t                               head,
  output logic                                full,
  output logic                                empty,
  output logic [CNT_W-1:0]                    count,
  output logic [DEPTH-1:0]                    ent_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]    ent_rd
);

  beat_t            mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; ent_valid (derived from the
  // pointers and count) is the only thing that says whether a slot matters.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_beat;
  end

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] offset;
      offset       = PTR_W'(i) - rd_ptr;
      ent_valid[i] = ({1'b0, offset} < count);
      ent_rd[i]    = mem[i].rd;
    end
  end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// rf_writeback_arbiter
// Merges the in-order pipeline writeback and the multi-cycle unit results into
// the single register-file write port. Pipeline has priority; the multi-cycle
// FIFO head is forced through after losing STARVE_LIMIT arbitrations in a row.
// x0 writes are filtered. rsN_busy reports writes still pending here so decode
// can stall on RAW hazards.
//
// Optional build macro: RF_WB_BYPASS_EN -- when defined, a multi-cycle beat
// arriving while the FIFO is empty and the pipeline is idle skips the FIFO and
// goes straight to the output register (1-cycle latency).
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   pipe_valid/rd/data    : pipeline result; pipe_stall tells upstream to hold
//   mc_valid/rd/data      : multi-cycle result; mc_ready is the handshake ready
//   chk_rs1/2, rs1/2_busy : decode scoreboard query / pending-write answer
//   rf_we/rf_rd/rf_din    : registered RF write port
// -----------------------------------------------------------------------------
module rf_writeback_arbiter
  import rf_writeback_arbiter_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_valid,
  input  logic [REG_ADDR_W-1:0] pipe_rd,
  input  logic [XLEN-1:0]       pipe_data,
  output logic                  pipe_stall,
  input  logic                  mc_valid,
  output logic                  mc_ready,
  input  logic [REG_ADDR_W-1:0] mc_rd,
  input  logic [XLEN-1:0]       mc_data,
  input  logic [REG_ADDR_W-1:0] chk_rs1,
  input  logic [REG_ADDR_W-1:0] chk_rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_din
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } beat_t;

  beat_t                             fifo_head;
  logic                              fifo_full;
  logic                              fifo_empty;
  logic [CNT_W-1:0]                  fifo_count;
  logic [DEPTH-1:0]                  ent_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0]  ent_rd;

  logic       mc_write;     // accepted mc beat that targets a real register
  logic       bypass_ok;
  logic       fifo_push;
  logic       fifo_pop;
  logic       force_fifo;
  logic [7:0] starve_cnt;
  wb_src_e    win;

  assign mc_ready   = !reset && !fifo_full;
  assign mc_write   = mc_valid && mc_ready && writes_reg(mc_rd);
  assign force_fifo = !fifo_empty && (starve_cnt == LIMIT);
  assign pipe_stall = pipe_valid && force_fifo;

`ifdef RF_WB_BYPASS_EN
  assign bypass_ok = fifo_empty && !pipe_valid && mc_write;
`else
  assign bypass_ok = 1'b0;
`endif

  assign fifo_push = mc_write && !bypass_ok;
  assign fifo_pop  = (win == WIN_FIFO);

  // An x0 pipeline beat still wins the slot, so the FIFO cannot steal it.
  // NOTE: every combinational output is given a default before any branch,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    win = WIN_NONE;
    if (force_fifo)       win = WIN_FIFO;
    else if (pipe_valid)  win = WIN_PIPE;
    else if (!fifo_empty) win = WIN_FIFO;
    else if (bypass_ok)   win = WIN_MC;
  end

  wb_fifo #(
    .DEPTH  (DEPTH),
    .beat_t (beat_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_beat ('{rd: mc_rd, data: mc_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .ent_valid (ent_valid),
    .ent_rd    (ent_rd)
  );

  // Output register: rd/din hold their last value when no write is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we  <= 1'b0;
      rf_rd  <= REG_ZERO;
      rf_din <= '0;
    end else begin
      rf_we <= 1'b0;
      case (win)
        WIN_PIPE: begin
          if (writes_reg(pipe_rd)) begin
            rf_we  <= 1'b1;
            rf_rd  <= pipe_rd;
            rf_din <= pipe_data;
          end
        end
        WIN_FIFO: begin
          rf_we  <= 1'b1;
          rf_rd  <= fifo_head.rd;
          rf_din <= fifo_head.data;
        end
        WIN_MC: begin
          rf_we  <= 1'b1;
          rf_rd  <= mc_rd;
          rf_din <= mc_data;
        end
        default: ;
      endcase
    end
  end

  // Counts consecutive losses of a waiting FIFO head to the pipeline.
  always_ff @(posedge clk) begin
    if (reset || fifo_empty || win == WIN_FIFO) begin
      starve_cnt <= '0;
    end else if (win == WIN_PIPE && starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Pending writes: queued FIFO entries plus the write currently on the port.
  always_comb begin
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && ent_rd[i] == chk_rs1) rs1_busy = 1'b1;
      if (ent_valid[i] && ent_rd[i] == chk_rs2) rs2_busy = 1'b1;
    end
    if (rf_we && rf_rd == chk_rs1) rs1_busy = 1'b1;
    if (rf_we && rf_rd == chk_rs2) rs2_busy = 1'b1;
    if (!writes_reg(chk_rs1)) rs1_busy = 1'b0;
    if (!writes_reg(chk_rs2)) rs2_busy = 1'b0;
  end

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_writeback_arbiter
// Directed self-checking bench for rf_writeback_arbiter (DEPTH=4,
// STARVE_LIMIT=8). Inputs change 1 time unit after the rising edge; outputs
// are sampled at that same point, so registered outputs reflect the edge just
// taken and combinational outputs reflect the freshly driven inputs.
// -----------------------------------------------------------------------------
module tb_rf_writeback_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        pipe_stall;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_rd;
  logic [31:0] mc_data;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_din;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rf_writeback_arbiter #(
    .XLEN(32), .DEPTH(4), .STARVE_LIMIT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .pipe_stall(pipe_stall),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_rd(mc_rd), .mc_data(mc_data),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_din(rf_din)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input string tag, input logic [4:0] rd,
                              input logic [31:0] data);
    check({tag, ".we"},  32'(rf_we),  32'd1);
    check({tag, ".rd"},  32'(rf_rd),  32'(rd));
    check({tag, ".din"}, rf_din,      data);
  endtask

  initial begin
    reset = 1'b1;
    pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
    mc_valid = 1'b0;   mc_rd = '0;   mc_data = '0;
    chk_rs1 = '0;      chk_rs2 = '0;

    // ---- reset state ----
    step(); step();
    check("rst.mc_ready", 32'(mc_ready), 32'd0);
    check("rst.we",       32'(rf_we),    32'd0);
    check("rst.rd",       32'(rf_rd),    32'd0);
    check("rst.din",      rf_din,        32'd0);
    reset = 1'b0;
    #1;
    check("post_rst.mc_ready", 32'(mc_ready), 32'd1);
    step();

    // ---- pipeline only: 1-cycle latency ----
    pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEAD;
    #1 check("pipe.stall", 32'(pipe_stall), 32'd0);
    step();
    expect_write("pipe", 5'd5, 32'hDEAD);
    pipe_valid = 1'b0;
    step();
    check("pipe.idle_we", 32'(rf_we), 32'd0);

    // ---- x0 filter ----
    pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = 32'h1234;
    mc_valid = 1'b1;   mc_rd = 5'd0;   mc_data = 32'h55;
    #1 check("x0.stall", 32'(pipe_stall), 32'd0);
    check("x0.mc_ready", 32'(mc_ready), 32'd1);
    step();
    check("x0.we1", 32'(rf_we), 32'd0);
    pipe_valid = 1'b0; mc_valid = 1'b0;
    step();
    // Had the mc x0 beat been queued, the idle slot would have issued it.
    check("x0.we2", 32'(rf_we), 32'd0);

    // ---- FIFO fill / full, then drain in order ----
    pipe_valid = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h100;
    for (int k = 0; k < 4; k++) begin
      mc_valid = 1'b1; mc_rd = 5'(10 + k); mc_data = 32'hA0 + 32'(k);
      step();
      expect_write("fill.pipe", 5'd1, 32'h100);
    end
    check("fill.full_ready", 32'(mc_ready), 32'd0);
    mc_rd = 5'd14; mc_data = 32'hA4;
    step();
    check("fill.still_full", 32'(mc_ready), 32'd0);
    expect_write("fill.pipe5", 5'd1, 32'h100);
    pipe_valid = 1'b0; mc_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      expect_write("drain", 5'(10 + k), 32'hA0 + 32'(k));
    end
    check("drain.ready", 32'(mc_ready), 32'd1);
    step();
    check("drain.idle_we", 32'(rf_we), 32'd0);

    // ---- starvation: forced issue after 8 pipeline wins ----
    pipe_valid = 1'b1; pipe_rd = 5'd2; pipe_data = 32'h300;
    mc_valid = 1'b1;   mc_rd = 5'd9;   mc_data = 32'h99;
    step();
    expect_write("starve.p0", 5'd2, 32'h300);
    mc_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      pipe_data = 32'h300 + 32'(i);
      #1 check("starve.nostall", 32'(pipe_stall), 32'd0);
      step();
      expect_write("starve.pwin", 5'd2, 32'h300 + 32'(i));
    end
    pipe_data = 32'h309;
    #1 check("starve.stall", 32'(pipe_stall), 32'd1);
    step();
    expect_write("starve.forced", 5'd9, 32'h99);
    check("starve.released", 32'(pipe_stall), 32'd0);
    step();
    expect_write("starve.held_beat", 5'd2, 32'h309);
    pipe_valid = 1'b0;
    step();
    check("starve.idle_we", 32'(rf_we), 32'd0);

    // ---- scoreboard ----
    chk_rs1 = 5'd7; chk_rs2 = 5'd0;
    pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h30;
    mc_valid = 1'b1;   mc_rd = 5'd7;   mc_data = 32'h77;
    #1 check("sb.incoming_not_busy", 32'(rs1_busy), 32'd0);
    step();
    check("sb.queued_busy", 32'(rs1_busy), 32'd1);
    check("sb.rs2_zero",    32'(rs2_busy), 32'd0);
    chk_rs2 = 5'd3;
    #1 check("sb.rs2_on_port", 32'(rs2_busy), 32'd1);
    chk_rs2 = 5'd0;
    pipe_valid = 1'b0; mc_valid = 1'b0;
    step();
    expect_write("sb.issue", 5'd7, 32'h77);
    check("sb.busy_during_we", 32'(rs1_busy), 32'd1);
    step();
    check("sb.cleared", 32'(rs1_busy), 32'd0);

    // ---- reset mid-operation ----
    pipe_valid = 1'b1; pipe_rd = 5'd4; pipe_data = 32'h40;
    for (int k = 0; k < 3; k++) begin
      mc_valid = 1'b1; mc_rd = 5'(20 + k); mc_data = 32'hC0 + 32'(k);
      step();
    end
    chk_rs1 = 5'd20;
    #1 check("mid.queued_busy", 32'(rs1_busy), 32'd1);
    reset = 1'b1; pipe_valid = 1'b0; mc_rd = 5'd23;
    #1 check("mid.ready_in_rst", 32'(mc_ready), 32'd0);
    step();
    check("mid.we_rst",   32'(rf_we),    32'd0);
    check("mid.ready_rst2", 32'(mc_ready), 32'd0);
    reset = 1'b0; mc_valid = 1'b0;
    #1 check("mid.sb_empty", 32'(rs1_busy), 32'd0);
    check("mid.ready_after", 32'(mc_ready), 32'd1);
    step();
    check("mid.no_stale1", 32'(rf_we), 32'd0);
    step();
    check("mid.no_stale2", 32'(rf_we), 32'd0);

    // ---- idle multi-cycle latency ----
    mc_valid = 1'b1; mc_rd = 5'd15; mc_data = 32'hF00D;
    step();
    mc_valid = 1'b0;
`ifdef RF_WB_BYPASS_EN
    expect_write("lat.bypass", 5'd15, 32'hF00D);
    step();
    check("lat.after", 32'(rf_we), 32'd0);
`else
    check("lat.cycle1", 32'(rf_we), 32'd0);
    step();
    expect_write("lat.cycle2", 5'd15, 32'hF00D);
`endif
    step();
    check("lat.idle", 32'(rf_we), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
